// File: rtl/ir_nec_if.sv
// Output channel of the NEC decoder: a valid/ready word stream plus error and overrun strobes.
// The decoder drives the bus through the master modport and the consumer uses the slave modport.
interface ir_nec_if;
    logic        i_READY;
    logic        o_VALID;
    logic [31:0] o_DATA;
    logic        o_REPEAT;
    logic        o_ERROR;
    logic        o_OVERRUN;

    modport master (
        input  i_READY,
        output o_VALID, o_DATA, o_REPEAT, o_ERROR, o_OVERRUN
    );

    modport slave (
        output i_READY,
        input  o_VALID, o_DATA, o_REPEAT, o_ERROR, o_OVERRUN
    );
endinterface

// File: rtl/ir_nec_decoder.sv
// NEC infrared receiver. It measures the mark and space widths on the demodulated line in
// 10 us ticks, decodes 32-bit frames and repeat codes, and hands the words out by valid/ready.
module ir_nec_decoder #(
    parameter int CLK_FREQ_HZ     = 50_000_000,
    parameter int TOL_PCT         = 20,
    parameter int IRDA_ACTIVE_LOW = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int CHECK_ADDR      = 1,
    parameter int REPEAT_EN       = 1
) (
    input  logic     i_CLOCK_POS,
    input  logic     i_RESET_POS,
    input  logic     i_IRDA,
    ir_nec_if.master bus
);

    localparam int DIV = CLK_FREQ_HZ / 100000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{IRDA_ACTIVE_LOW != 0}};

    function automatic logic [11:0] lo_b(input int n);
        return 12'(n * (100 - TOL_PCT) / 100);
    endfunction

    function automatic logic [11:0] hi_b(input int n);
        return 12'(n * (100 + TOL_PCT) / 100);
    endfunction

    function automatic logic in_win(input logic [11:0] w, input logic [11:0] lo,
                                    input logic [11:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    localparam logic [11:0] LM_LO = lo_b(900), LM_HI = hi_b(900);
    localparam logic [11:0] LS_LO = lo_b(450), LS_HI = hi_b(450);
    localparam logic [11:0] RS_LO = lo_b(225), RS_HI = hi_b(225);
    localparam logic [11:0] BM_LO = lo_b(56),  BM_HI = hi_b(56);
    localparam logic [11:0] ZS_LO = lo_b(56),  ZS_HI = hi_b(56);
    localparam logic [11:0] OS_LO = lo_b(169), OS_HI = hi_b(169);

    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, CHECK
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   mark_q, mark_d;
    logic                   edge_q, edge_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic                   tick;
    logic [11:0]            width_q, width_d;
    logic [4:0]             bitcnt_q, bitcnt_d;
    logic [31:0]            shift_q, shift_d;
    logic                   rpt_q, rpt_d;
    logic                   lv_q, lv_d;
    logic [31:0]            last_q, last_d;
    logic                   valid_q, valid_d;
    logic [31:0]            data_q, data_d;
    logic                   rptout_q, rptout_d;
    logic                   err_q, err_d;
    logic                   ovr_q, ovr_d;
    logic                   deliver;
    logic [31:0]            item_data;
    logic                   item_rpt;
    logic                   frame_ok;

    // Input path: synchroniser, mark=1 normalisation, registered edge strobe
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], i_IRDA};
    assign mark_d  = (IRDA_ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
    assign edge_d  = mark_d ^ mark_q;

    // Timing: 10 us tick and saturating width of the current line level
    assign tick    = (presc_q == PRE_MAX);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        width_d = width_q;
        if (edge_q) begin
            width_d = '0;
        end else if (tick && (width_q != 12'hFFF)) begin
            width_d = width_q + 12'd1;
        end
    end

    assign frame_ok = (shift_q[31:24] == ~shift_q[23:16]) &&
                      ((CHECK_ADDR == 0) || (shift_q[15:8] == ~shift_q[7:0]));

    // Frame FSM: an edge ends the measured segment, otherwise the width is checked for timeout
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rpt_d     = rpt_q;
        lv_d      = lv_q;
        last_d    = last_q;
        err_d     = 1'b0;
        deliver   = 1'b0;
        item_data = shift_q;
        item_rpt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (edge_q && mark_q) state_d = LEAD_MARK;
            end
            LEAD_MARK: begin
                if (edge_q) begin
                    state_d = in_win(width_q, LM_LO, LM_HI) ? LEAD_SPACE : IDLE;
                end else if (width_q > LM_HI) begin
                    err_d = 1'b1;
                end
            end
            LEAD_SPACE: begin
                if (edge_q) begin
                    if (in_win(width_q, LS_LO, LS_HI)) begin
                        bitcnt_d = '0;
                        shift_d  = '0;
                        rpt_d    = 1'b0;
                        state_d  = BIT_MARK;
                    end else if ((REPEAT_EN != 0) && in_win(width_q, RS_LO, RS_HI)) begin
                        rpt_d   = 1'b1;
                        state_d = STOP_MARK;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (width_q > LS_HI) begin
                    err_d = 1'b1;
                end
            end
            BIT_MARK: begin
                if (edge_q) begin
                    if (in_win(width_q, BM_LO, BM_HI)) state_d = BIT_SPACE;
                    else                               err_d   = 1'b1;
                end else if (width_q > BM_HI) begin
                    err_d = 1'b1;
                end
            end
            BIT_SPACE: begin
                if (edge_q) begin
                    if (in_win(width_q, ZS_LO, ZS_HI) || in_win(width_q, OS_LO, OS_HI)) begin
                        shift_d  = {in_win(width_q, OS_LO, OS_HI), shift_q[31:1]};
                        bitcnt_d = bitcnt_q + 5'd1;
                        state_d  = (bitcnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (width_q > OS_HI) begin
                    err_d = 1'b1;
                end
            end
            STOP_MARK: begin
                if (edge_q) begin
                    if (in_win(width_q, BM_LO, BM_HI)) state_d = CHECK;
                    else                               err_d   = 1'b1;
                end else if (width_q > BM_HI) begin
                    err_d = 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (rpt_q) begin
                    if (lv_q) begin
                        deliver   = 1'b1;
                        item_data = last_q;
                        item_rpt  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (frame_ok) begin
                    deliver = 1'b1;
                    lv_d    = 1'b1;
                    last_d  = shift_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (err_d) begin
            state_d = IDLE;
            lv_d    = 1'b0;
        end
    end

    // Output stage: a held item is never replaced, a blocked delivery becomes an overrun
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        rptout_d = rptout_q;
        ovr_d    = 1'b0;
        if (deliver) begin
            if (!valid_q || bus.i_READY) begin
                valid_d  = 1'b1;
                data_d   = item_data;
                rptout_d = item_rpt;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.i_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            state_q  <= IDLE;
            sync_q   <= SYNC_IDLE;
            mark_q   <= 1'b0;
            edge_q   <= 1'b0;
            presc_q  <= '0;
            width_q  <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            rpt_q    <= 1'b0;
            lv_q     <= 1'b0;
            last_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            rptout_q <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            mark_q   <= mark_d;
            edge_q   <= edge_d;
            presc_q  <= presc_d;
            width_q  <= width_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            rpt_q    <= rpt_d;
            lv_q     <= lv_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            rptout_q <= rptout_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.o_VALID   = valid_q;
    assign bus.o_DATA    = data_q;
    assign bus.o_REPEAT  = rptout_q;
    assign bus.o_ERROR   = err_q;
    assign bus.o_OVERRUN = ovr_q;

endmodule

// File: doc/ir_nec_decoder.md
Name: ir_nec_decoder

Overview:
- Parametrised next-generation NEC infrared receiver. It decodes 32-bit NEC frames and NEC repeat codes from a demodulated IR sensor line.
- Timing is derived from the clock frequency and a tolerance window, not fixed cycle constants.
- Decoded words go to downstream logic (UART bridge, display, control FSMs) through a valid/ready handshake, with repeat, error and overrun reporting.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency. Must be an exact multiple of 100000.
- TOL_PCT, 20, accepted timing deviation in percent, range 5..40.
- IRDA_ACTIVE_LOW, 1. When 1, a low input means carrier present (mark).
- SYNC_STAGES, 2, input synchroniser depth, minimum 2.
- CHECK_ADDR, 1. When 1, also require data[15:8] == ~data[7:0]. When 0, extended 16-bit addresses are allowed.
- REPEAT_EN, 1, enables decoding of repeat codes.

Ports:
- i_CLOCK_POS  in  1  system clock; all logic on the rising edge.
- i_RESET_POS  in  1  reset; synchronous, active-high.
- i_IRDA  in  1  raw asynchronous IR sensor output.
- i_READY  in  1  consumer ready.
- o_VALID  out  1  o_DATA/o_REPEAT hold an unconsumed item.
- o_DATA  out  32  decoded frame; first received bit lands in [0].
- o_REPEAT  out  1  item is a repeat of the last valid frame.
- o_ERROR  out  1  one-cycle pulse: malformed frame or checksum failure.
- o_OVERRUN  out  1  one-cycle pulse: a completed item was dropped.

Behaviour:
- Reset (sampled on i_CLOCK_POS while i_RESET_POS=1): FSM goes to IDLE; synchroniser, tick and width counters clear; last_valid is cleared; all outputs go to 0. Reset mid-frame discards the partial frame.
- Input path: SYNC_STAGES flip-flops, then polarity normalisation (mark=1), then a one-cycle registered edge detect.
- Tick counter: a prescaler of CLK_FREQ_HZ/100000 cycles produces a 10 us tick.
- Width counter: 12 bits, counts ticks, saturates at 4095, clears on every edge of the synchronised line.
- Nominal durations in ticks:
  - LEAD_MARK 900
  - LEAD_SPACE 450
  - RPT_SPACE 225
  - BIT_MARK 56
  - ZERO_SPACE 56
  - ONE_SPACE 169
- Window test: a width w matches nominal N when N*(100-TOL_PCT)/100 <= w <= N*(100+TOL_PCT)/100. Bounds use integer floor and are elaborated at compile time.
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, CHECK.
  - IDLE: a mark start goes to LEAD_MARK.
  - LEAD_MARK: at mark end, if the width is in the LEAD_MARK window go to LEAD_SPACE, else go to IDLE silently (noise rejection, no error).
  - LEAD_SPACE: at space end, a LEAD_SPACE match clears the bit counter and shift register and goes to BIT_MARK. A RPT_SPACE match with REPEAT_EN=1 sets the repeat flag and goes to STOP_MARK. Anything else is an error.
  - BIT_MARK: mark end within the BIT_MARK window goes to BIT_SPACE, else error.
  - BIT_SPACE: at space end, a ZERO_SPACE match shifts in 0 and a ONE_SPACE match shifts in 1 (LSB-first, shifting right). After the 32nd bit go to STOP_MARK, else go to BIT_MARK. Any other width is an error.
  - STOP_MARK: mark end within the BIT_MARK window goes to CHECK, else error.
  - CHECK (one cycle):
    - Frame path: passes if data[31:24] == ~data[23:16], and, when CHECK_ADDR=1, data[15:8] == ~data[7:0]. Pass: deliver the frame and set last_valid. Fail: error.
    - Repeat path: delivers the stored last frame with o_REPEAT=1 if last_valid=1. If last_valid=0 it is an error.
- Timeout: in any non-IDLE state, if the width counter exceeds the upper bound of the largest window allowed in that state, raise an error. This covers a line stuck at one level.
- Error action: pulse o_ERROR for one cycle, clear last_valid, go to IDLE. Error never disturbs a pending output item.
- Delivery:
  - o_VALID, o_DATA and o_REPEAT are registered and assert on the cycle after CHECK. Latency from the raw stop-mark end edge is SYNC_STAGES+3 clocks (+1 for asynchronous sampling).
  - A handshake occurs on a rising edge with o_VALID=1 and i_READY=1. o_VALID then drops the next cycle unless a new item is delivered on that same edge, in which case it is loaded and o_VALID stays 1.
  - o_DATA and o_REPEAT stay stable while o_VALID=1 and i_READY=0.
  - If CHECK completes while o_VALID=1 and i_READY=0, the new item is dropped, the old item is kept, o_OVERRUN pulses for one cycle, and last_valid is still updated on a checksum pass.
- Decoding continues regardless of i_READY.

Test Plan:
(All tests use CLK_FREQ_HZ=1000000, TOL_PCT=20, i_IRDA active-low.)
- Nominal frame, addr 0x00, cmd 0x45, i_READY=1 -> one o_VALID cycle with o_DATA=0xBA45FF00, o_REPEAT=0, no o_ERROR.
- Same frame, then after 40 ms a repeat code (9 ms mark, 2.25 ms space, 560 us mark) -> second item with o_DATA=0xBA45FF00 and o_REPEAT=1.
- Hold i_READY=0, send two frames (cmd 0x45, then 0x46), then raise i_READY -> o_OVERRUN pulses once at the second CHECK; the single item delivered is 0xBA45FF00.
- Cmd complement corrupted (byte3=0xBB), followed by a repeat code -> o_ERROR pulses twice (checksum, then repeat with last_valid=0); o_VALID is never asserted.
- 6 ms lead mark, then idle -> no o_ERROR, no o_VALID. Lead mark and space OK but a 1.2 ms bit mark -> o_ERROR pulse, FSM returns to IDLE.
- Extended address 0x1234, cmd 0x45: with CHECK_ADDR=1 -> o_ERROR. With CHECK_ADDR=0 -> o_DATA=0xBA451234. Reset asserted after 16 bits, then a full frame -> only the post-reset frame is delivered.
